// File: rtl/ddr_wr_arb.sv
// Round-robin arbiter granting one write requester at a time to a shared DDR write engine.
// Latency: grant, address and length appear 1 cycle after selection; done_o follows the engine done edge by 1 cycle.
// Backpressure: requesters hold req_i until done_o; the engine holds off completion by keeping wr_ddr_done_i low, bounded by the timeout.
module ddr_wr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 8,
    parameter int TMO_W   = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic                      wr_ddr_en_o,
    output logic [ADDR_W-1:0]         wr_ddr_addr_o,
    output logic [LEN_W-1:0]          wr_ddr_len_o,
    input  logic                      wr_ddr_done_i,
    output logic                      busy_o,
    output logic                      err_tmo_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    // Last counter value seen in WRITE before the limit is reached on the following edge.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CPL   = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_win;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_done;
    logic               r_en;
    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_len;
    logic               r_err;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_done_prev;

    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic [NUM_REQ-1:0] w_gnt_sel;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [LEN_W-1:0]   w_sel_len;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic               w_done_edge;

    // Pick the first active requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_i[(int'(r_rr_ptr) + i) % NUM_REQ]) begin
                w_found = 1'b1;
                w_win   = IDX_W'((int'(r_rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign w_gnt_sel   = NUM_REQ'(1) << w_win;
    assign w_sel_addr  = req_addr_i[int'(w_win)*ADDR_W +: ADDR_W];
    assign w_sel_len   = req_len_i[int'(w_win)*LEN_W +: LEN_W];
    assign w_ptr_nxt   = (r_win == IDX_W'(NUM_REQ-1)) ? '0 : r_win + 1'b1;
    // Only a fresh 0->1 transition counts, so a done left high by the last write is ignored.
    assign w_done_edge = wr_ddr_done_i & ~r_done_prev;

    // Service FSM: grant and latch in IDLE, wait for done edge or timeout in WRITE, pulse done in CPL.
    // A zero-length request spends its grant cycle in WRITE with the enable held off.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_win       <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_en        <= 1'b0;
            r_addr      <= '0;
            r_len       <= '0;
            r_err       <= 1'b0;
            r_tmo       <= '0;
            r_done_prev <= 1'b0;
        end else begin
            r_done_prev <= wr_ddr_done_i;
            r_done      <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= w_gnt_sel;
                        r_win   <= w_win;
                        r_addr  <= w_sel_addr;
                        r_len   <= w_sel_len;
                        r_en    <= (w_sel_len != '0);
                        r_tmo   <= '0;
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (r_len == '0) begin
                        r_done  <= r_gnt;
                        r_state <= ST_CPL;
                    end else if (w_done_edge) begin
                        r_en    <= 1'b0;
                        r_done  <= r_gnt;
                        r_state <= ST_CPL;
                    end else if (r_tmo == TMO_LAST) begin
                        r_en    <= 1'b0;
                        r_err   <= 1'b1;
                        r_done  <= r_gnt;
                        r_state <= ST_CPL;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_CPL: begin
                    r_gnt    <= '0;
                    r_rr_ptr <= w_ptr_nxt;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_o         = r_gnt;
    assign done_o        = r_done;
    assign wr_ddr_en_o   = r_en;
    assign wr_ddr_addr_o = r_addr;
    assign wr_ddr_len_o  = r_len;
    assign busy_o        = (r_state != ST_IDLE);
    assign err_tmo_o     = r_err;

endmodule

// File: tb/tb_ddr_wr_arb.sv
// Directed bench for ddr_wr_arb: one default instance plus one with a short timeout.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Expected values are hand-derived cycle by cycle from the intended service sequence.
module tb_ddr_wr_arb;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req;
    logic [NR*AW-1:0] req_addr;
    logic [NR*LW-1:0] req_len;
    logic          ddr_done;
    logic [NR-1:0] gnt, done;
    logic          en, busy, err;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;

    logic          rst_t;
    logic [NR-1:0] req_t;
    logic          ddr_done_t;
    logic [NR-1:0] gnt_t, done_t;
    logic          en_t, busy_t, err_t;
    logic [AW-1:0] addr_t;
    logic [LW-1:0] len_t;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ddr_wr_arb #(.NUM_REQ(NR), .ADDR_W(AW), .LEN_W(LW), .TMO_W(12)) u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .req_addr_i(req_addr), .req_len_i(req_len),
        .gnt_o(gnt), .done_o(done), .wr_ddr_en_o(en), .wr_ddr_addr_o(addr),
        .wr_ddr_len_o(len), .wr_ddr_done_i(ddr_done), .busy_o(busy), .err_tmo_o(err)
    );

    ddr_wr_arb #(.NUM_REQ(NR), .ADDR_W(AW), .LEN_W(LW), .TMO_W(4)) u_dut_tmo (
        .clk_i(clk), .rst_i(rst_t), .req_i(req_t), .req_addr_i(req_addr), .req_len_i(req_len),
        .gnt_o(gnt_t), .done_o(done_t), .wr_ddr_en_o(en_t), .wr_ddr_addr_o(addr_t),
        .wr_ddr_len_o(len_t), .wr_ddr_done_i(ddr_done_t), .busy_o(busy_t), .err_tmo_o(err_t)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        rst_t      = 1'b1;
        req        = '0;
        req_t      = '0;
        ddr_done   = 1'b0;
        ddr_done_t = 1'b0;
        for (int k = 0; k < NR; k++) begin
            req_addr[k*AW +: AW] = 32'h1000_0000 + 32'(k) * 32'h100;
            req_len[k*LW +: LW]  = 8'd1;
        end
        step();
        step();

        // Reset state
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_en", 64'(en), 64'h0);
        chk("rst_addr", 64'(addr), 64'h0);
        chk("rst_len", 64'(len), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        rst   = 1'b0;
        rst_t = 1'b0;
        step();

        // Single request, len 16, engine done after 16 enabled cycles
        req_len[0*LW +: LW] = 8'd16;
        req = 4'b0001;
        step();
        chk("single_gnt", 64'(gnt), 64'h1);
        chk("single_en", 64'(en), 64'h1);
        chk("single_addr", 64'(addr), 64'h1000_0000);
        chk("single_len", 64'(len), 64'd16);
        chk("single_busy", 64'(busy), 64'h1);
        // Changing the requester's length mid-service must not be picked up
        req_len[0*LW +: LW] = 8'd5;
        for (int c = 0; c < 15; c++) step();
        chk("single_en_held", 64'(en), 64'h1);
        chk("single_len_held", 64'(len), 64'd16);
        chk("single_no_done", 64'(done), 64'h0);
        ddr_done = 1'b1;
        step();
        chk("single_done", 64'(done), 64'h1);
        chk("single_en_off", 64'(en), 64'h0);
        chk("single_gnt_cpl", 64'(gnt), 64'h1);
        req      = 4'b0000;
        ddr_done = 1'b0;
        step();
        chk("single_gnt_clr", 64'(gnt), 64'h0);
        chk("single_done_clr", 64'(done), 64'h0);
        chk("single_idle", 64'(busy), 64'h0);

        // Round robin from pointer 0 with all requesters held high
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < NR; k++) req_len[k*LW +: LW] = 8'd1;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            step();
            chk($sformatf("rr_gnt%0d", g), 64'(gnt), 64'(4'b0001 << (g % 4)));
            chk($sformatf("rr_en%0d", g), 64'(en), 64'h1);
            ddr_done = 1'b1;
            step();
            chk($sformatf("rr_done%0d", g), 64'(done), 64'(4'b0001 << (g % 4)));
            ddr_done = 1'b0;
            if (g == 4) req = 4'b0000;
            step();
            chk($sformatf("rr_bubble%0d", g), 64'(gnt), 64'h0);
        end

        // Stale done: engine done still high when requester 1 is granted
        ddr_done = 1'b1;
        step();
        step();
        req_len[1*LW +: LW] = 8'd4;
        req = 4'b0010;
        step();
        chk("stale_gnt", 64'(gnt), 64'h2);
        chk("stale_addr", 64'(addr), 64'h1000_0100);
        for (int c = 0; c < 3; c++) step();
        chk("stale_en", 64'(en), 64'h1);
        chk("stale_no_done", 64'(done), 64'h0);
        ddr_done = 1'b0;
        step();
        chk("stale_en_low", 64'(en), 64'h1);
        ddr_done = 1'b1;
        step();
        chk("stale_done", 64'(done), 64'h2);
        chk("stale_en_off", 64'(en), 64'h0);
        ddr_done = 1'b0;
        req      = 4'b0000;
        step();
        chk("stale_gnt_clr", 64'(gnt), 64'h0);

        // Zero length on requester 2
        req_len[2*LW +: LW] = 8'd0;
        req = 4'b0100;
        step();
        chk("zero_gnt", 64'(gnt), 64'h4);
        chk("zero_en1", 64'(en), 64'h0);
        chk("zero_busy", 64'(busy), 64'h1);
        chk("zero_nodone1", 64'(done), 64'h0);
        step();
        chk("zero_done", 64'(done), 64'h4);
        chk("zero_en2", 64'(en), 64'h0);
        req = 4'b0000;
        step();
        chk("zero_gnt_clr", 64'(gnt), 64'h0);

        // Reset in WRITE cycle 5, then re-grant from pointer 0
        req_len[1*LW +: LW] = 8'd8;
        req = 4'b0010;
        step();
        chk("rstw_gnt", 64'(gnt), 64'h2);
        for (int c = 0; c < 4; c++) step();
        chk("rstw_en5", 64'(en), 64'h1);
        rst = 1'b1;
        step();
        chk("rstw_gnt0", 64'(gnt), 64'h0);
        chk("rstw_en0", 64'(en), 64'h0);
        chk("rstw_done0", 64'(done), 64'h0);
        chk("rstw_busy0", 64'(busy), 64'h0);
        chk("rstw_addr0", 64'(addr), 64'h0);
        rst = 1'b0;
        step();
        chk("rstw_regnt", 64'(gnt), 64'h2);
        chk("rstw_reen", 64'(en), 64'h1);
        ddr_done = 1'b1;
        step();
        chk("rstw_done", 64'(done), 64'h2);
        ddr_done = 1'b0;
        req      = 4'b0000;
        step();

        // Timeout on the short-timeout instance: limit 15 WRITE cycles
        req_len[0*LW +: LW] = 8'd16;
        req_t = 4'b0001;
        step();
        chk("tmo_gnt", 64'(gnt_t), 64'h1);
        chk("tmo_en1", 64'(en_t), 64'h1);
        for (int c = 0; c < 14; c++) step();
        chk("tmo_en15", 64'(en_t), 64'h1);
        chk("tmo_err_before", 64'(err_t), 64'h0);
        step();
        chk("tmo_en_off", 64'(en_t), 64'h0);
        chk("tmo_err", 64'(err_t), 64'h1);
        chk("tmo_done", 64'(done_t), 64'h1);
        req_t = 4'b0000;
        step();
        chk("tmo_gnt_clr", 64'(gnt_t), 64'h0);
        step();
        step();
        chk("tmo_err_sticky", 64'(err_t), 64'h1);
        rst_t = 1'b1;
        step();
        chk("tmo_err_rst", 64'(err_t), 64'h0);
        rst_t = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
